capture_shift_ctrl: RTL and testbench

Sequences the parallel-in/serial-out shift register chain that captures DUT output pins. On a START request it parallel-loads the chain, then clocks it out bit by bit, sampling the serial data return Q into a WIDTH-bit capture word. It sits between the central tester FSM, which requests captures and consumes the word, and the off-chip PL_BAR/SHCP/Q pins.

---
 rtl/capture_shift_ctrl_if.sv | 36 +++
 rtl/capture_shift_ctrl.sv | 151 +++++++++++++++
 tb/tb_capture_shift_ctrl.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/capture_shift_ctrl_if.sv
// Bundles the tester-side request/word handshake and the chain pins (PL_BAR/SHCP/Q).
// Compare ports are present only when CAPTURE_COMPARE_EN is defined.
interface capture_shift_ctrl_if #(
    parameter int WIDTH = 128
);
    logic             start_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] data_o;
    logic             pl_bar_o;
    logic             shcp_o;
    logic             q_i;
`ifdef CAPTURE_COMPARE_EN
    logic [WIDTH-1:0] expected_i;
    logic [WIDTH-1:0] mask_i;
    logic             mismatch_o;

    modport slave (
        input  start_i, q_i, expected_i, mask_i,
        output busy_o, done_o, data_o, pl_bar_o, shcp_o, mismatch_o
    );
    modport master (
        output start_i, q_i, expected_i, mask_i,
        input  busy_o, done_o, data_o, pl_bar_o, shcp_o, mismatch_o
    );
`else
    modport slave (
        input  start_i, q_i,
        output busy_o, done_o, data_o, pl_bar_o, shcp_o
    );
    modport master (
        output start_i, q_i,
        input  busy_o, done_o, data_o, pl_bar_o, shcp_o
    );
`endif
endinterface

// File: rtl/capture_shift_ctrl.sv
// Sequences a PISO capture chain: parallel load, settle, then WIDTH samples of Q with WIDTH-1 SHCP pulses.
// Optional masked compare against an expected word is enabled by defining CAPTURE_COMPARE_EN.
module capture_shift_ctrl #(
    parameter int WIDTH = 128,
    parameter int DIV   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    capture_shift_ctrl_if.slave bus
);
    localparam int PHASE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BIT_W   = $clog2(WIDTH);
    localparam logic [PHASE_W-1:0] PHASE_MAX = PHASE_W'(DIV - 1);
    localparam logic [BIT_W-1:0]   BIT_MAX   = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        SHIFT_LO,
        SHIFT_HI,
        FINISH
    } state_t;

    state_t             state_q;
    logic [PHASE_W-1:0] phase_q;
    logic [BIT_W-1:0]   bit_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   data_q;
    logic               pl_bar_q;
    logic               shcp_q;
    logic [WIDTH-1:0]   data_d;
    logic               phase_last;

    // The word as it will look once the current Q sample is shifted in.
    assign data_d     = {data_q[WIDTH-2:0], bus.q_i};
    assign phase_last = (phase_q == '0);

`ifdef CAPTURE_COMPARE_EN
    logic [WIDTH-1:0] expected_q;
    logic [WIDTH-1:0] mask_q;
    logic             mismatch_q;
    logic [WIDTH-1:0] diff_d;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cmp
        assign diff_d[gi] = (data_d[gi] ^ expected_q[gi]) & mask_q[gi];
    end

    assign bus.mismatch_o = mismatch_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            bit_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            data_q     <= '0;
            pl_bar_q   <= 1'b1;
            shcp_q     <= 1'b0;
`ifdef CAPTURE_COMPARE_EN
            expected_q <= '0;
            mask_q     <= '0;
            mismatch_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start_i) begin
                        state_q  <= LOAD;
                        phase_q  <= PHASE_MAX;
                        bit_q    <= BIT_MAX;
                        busy_q   <= 1'b1;
                        pl_bar_q <= 1'b0;
`ifdef CAPTURE_COMPARE_EN
                        expected_q <= bus.expected_i;
                        mask_q     <= bus.mask_i;
                        mismatch_q <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (phase_last) begin
                        state_q  <= SETTLE;
                        phase_q  <= PHASE_MAX;
                        pl_bar_q <= 1'b1;
                    end else begin
                        phase_q <= phase_q - 1'b1;
                    end
                end
                SETTLE: begin
                    if (phase_last) begin
                        state_q <= SHIFT_LO;
                        phase_q <= PHASE_MAX;
                    end else begin
                        phase_q <= phase_q - 1'b1;
                    end
                end
                SHIFT_LO: begin
                    if (phase_last) begin
                        data_q <= data_d;
                        if (bit_q == '0) begin
                            // Last sample: no trailing SHCP edge is issued.
                            state_q <= FINISH;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
`ifdef CAPTURE_COMPARE_EN
                            mismatch_q <= |diff_d;
`endif
                        end else begin
                            state_q <= SHIFT_HI;
                            phase_q <= PHASE_MAX;
                            shcp_q  <= 1'b1;
                        end
                    end else begin
                        phase_q <= phase_q - 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (phase_last) begin
                        state_q <= SHIFT_LO;
                        phase_q <= PHASE_MAX;
                        shcp_q  <= 1'b0;
                        bit_q   <= bit_q - 1'b1;
                    end else begin
                        phase_q <= phase_q - 1'b1;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    pl_bar_q <= 1'b1;
                    shcp_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o   = busy_q;
    assign bus.done_o   = done_q;
    assign bus.data_o   = data_q;
    assign bus.pl_bar_o = pl_bar_q;
    assign bus.shcp_o   = shcp_q;

endmodule

// File: tb/tb_capture_shift_ctrl.sv
// Directed bench: three controller instances (8/2, 8/1, 128/4) each driving a behavioural PISO chain.
// Compare-port checks are included when CAPTURE_COMPARE_EN is defined.
module tb_capture_shift_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic clr;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    capture_shift_ctrl_if #(.WIDTH(8))   bus_a ();
    capture_shift_ctrl_if #(.WIDTH(8))   bus_b ();
    capture_shift_ctrl_if #(.WIDTH(128)) bus_c ();

    capture_shift_ctrl #(.WIDTH(8),   .DIV(2)) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    capture_shift_ctrl #(.WIDTH(8),   .DIV(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    capture_shift_ctrl #(.WIDTH(128), .DIV(4)) u_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    // Behavioural chains: load while PL_BAR low, shift toward Q on each SHCP rise.
    logic [7:0]   pat_a, chain_a, pat_b, chain_b;
    logic [127:0] pat_c, chain_c;
    logic         sp_a, sp_b, sp_c;
    int           rise_a, pll_a, done_cnt_a;
    int           rise_b, hi_b;
    int           rise_c;

    assign bus_a.q_i = chain_a[7];
    assign bus_b.q_i = chain_b[7];
    assign bus_c.q_i = chain_c[127];

    always @(posedge clk) begin
        if (!bus_a.pl_bar_o) chain_a <= pat_a;
        else if (bus_a.shcp_o && !sp_a) chain_a <= {chain_a[6:0], 1'b0};
        sp_a <= bus_a.shcp_o;
        if (clr) begin
            rise_a <= 0; pll_a <= 0; done_cnt_a <= 0;
        end else begin
            if (bus_a.shcp_o && !sp_a) rise_a <= rise_a + 1;
            if (!bus_a.pl_bar_o) pll_a <= pll_a + 1;
            if (bus_a.done_o) done_cnt_a <= done_cnt_a + 1;
        end
    end

    always @(posedge clk) begin
        if (!bus_b.pl_bar_o) chain_b <= pat_b;
        else if (bus_b.shcp_o && !sp_b) chain_b <= {chain_b[6:0], 1'b0};
        sp_b <= bus_b.shcp_o;
        if (clr) begin
            rise_b <= 0; hi_b <= 0;
        end else begin
            if (bus_b.shcp_o && !sp_b) rise_b <= rise_b + 1;
            if (bus_b.shcp_o) hi_b <= hi_b + 1;
        end
    end

    always @(posedge clk) begin
        if (!bus_c.pl_bar_o) chain_c <= pat_c;
        else if (bus_c.shcp_o && !sp_c) chain_c <= {chain_c[126:0], 1'b0};
        sp_c <= bus_c.shcp_o;
        if (clr) rise_c <= 0;
        else if (bus_c.shcp_o && !sp_c) rise_c <= rise_c + 1;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_done(input int which);
        case (which)
            0:       return bus_a.done_o;
            1:       return bus_b.done_o;
            default: return bus_c.done_o;
        endcase
    endfunction

    function automatic logic get_busy(input int which);
        case (which)
            0:       return bus_a.busy_o;
            1:       return bus_b.busy_o;
            default: return bus_c.busy_o;
        endcase
    endfunction

    task automatic set_start(input int which, input logic v);
        case (which)
            0:       bus_a.start_i = v;
            1:       bus_b.start_i = v;
            default: bus_c.start_i = v;
        endcase
    endtask

    // Clears monitors, pulses START for one edge; returns at the first cycle after the accepting edge.
    task automatic pulse_start(input int which, output logic busy1);
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        set_start(which, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(which, 1'b0);
        busy1 = get_busy(which);
    endtask

    // Cycle numbering: cycle 1 is the one right after the START edge; returns the cycle DONE is seen.
    task automatic wait_done(input int which, input int budget, output int cyc);
        cyc = 1;
        while (!get_done(which) && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        if (!get_done(which)) cyc = -1;
    endtask

    task automatic run_cap(input int which, input int budget, output int cyc, output logic busy1);
        pulse_start(which, busy1);
        wait_done(which, budget, cyc);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cyc;
        logic       b1;
        logic [7:0] pats [3];
        pats = '{8'h3C, 8'hC3, 8'hFF};

        rst_n = 1'b0;
        clr   = 1'b0;
        bus_a.start_i = 1'b0;
        bus_b.start_i = 1'b0;
        bus_c.start_i = 1'b0;
        pat_a = 8'h00; pat_b = 8'h00; pat_c = '0;
`ifdef CAPTURE_COMPARE_EN
        bus_a.expected_i = '0; bus_a.mask_i = '0;
        bus_b.expected_i = '0; bus_b.mask_i = '0;
        bus_c.expected_i = '0; bus_c.mask_i = '0;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy",   bus_a.busy_o,   1'b0);
        check("rst_done",   bus_a.done_o,   1'b0);
        check("rst_data",   bus_a.data_o,   8'h00);
        check("rst_pl_bar", bus_a.pl_bar_o, 1'b1);
        check("rst_shcp",   bus_a.shcp_o,   1'b0);
`ifdef CAPTURE_COMPARE_EN
        check("rst_mismatch", bus_a.mismatch_o, 1'b0);
`endif
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_pl_bar", bus_a.pl_bar_o, 1'b1);

        // 8 bits, DIV=2, pattern A5
        pat_a = 8'hA5;
        run_cap(0, 100, cyc, b1);
        check("t1_busy_after_start", b1, 1'b1);
        check("t1_done_cycle", cyc, 35);
        check("t1_busy_at_done", bus_a.busy_o, 1'b0);
        check("t1_data", bus_a.data_o, 8'hA5);
        check("t1_shcp_rises", rise_a, 7);
        check("t1_pl_bar_low_cycles", pll_a, 2);
        repeat (3) @(negedge clk);
        check("t1_data_hold", bus_a.data_o, 8'hA5);
        check("t1_done_single", done_cnt_a, 1);

        // 8 bits, DIV=1, pattern 01
        pat_b = 8'h01;
        run_cap(1, 100, cyc, b1);
        check("t2_done_cycle", cyc, 18);
        check("t2_data", bus_b.data_o, 8'h01);
        check("t2_shcp_rises", rise_b, 7);
        check("t2_shcp_high_cycles", hi_b, 7);

        // START held high across three captures
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        pat_a = pats[0];
        bus_a.start_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!bus_a.done_o && cyc < 200);
            check($sformatf("t3_data_%0d", i), bus_a.data_o, {120'd0, pats[i]});
            check($sformatf("t3_gap_%0d", i), cyc, (i == 0) ? 35 : 36);
            if (i < 2) pat_a = pats[i+1];
            else bus_a.start_i = 1'b0;
        end
        repeat (45) @(negedge clk);
        check("t3_done_pulses", done_cnt_a, 3);
        check("t3_idle_busy", bus_a.busy_o, 1'b0);
        check("t3_data_hold", bus_a.data_o, 8'hFF);

        // Reset in the middle of shifting, at bit 4
        pat_a = 8'h96;
        pulse_start(0, b1);
        cyc = 0;
        while (!(rise_a == 3 && !bus_a.shcp_o) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("t4_reached_bit4", rise_a, 3);
        check("t4_busy_before_rst", bus_a.busy_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check("t4_rst_pl_bar", bus_a.pl_bar_o, 1'b1);
        check("t4_rst_shcp",   bus_a.shcp_o,   1'b0);
        check("t4_rst_data",   bus_a.data_o,   8'h00);
        check("t4_rst_busy",   bus_a.busy_o,   1'b0);
        check("t4_rst_done",   bus_a.done_o,   1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("t4_no_done", done_cnt_a, 0);
        pat_a = 8'h5A;
        run_cap(0, 100, cyc, b1);
        check("t4_recover_cycle", cyc, 35);
        check("t4_recover_data", bus_a.data_o, 8'h5A);

`ifdef CAPTURE_COMPARE_EN
        // Masked compare: F0 vs F1
        pat_a = 8'hF0;
        bus_a.expected_i = 8'hF1;
        bus_a.mask_i     = 8'hFF;
        run_cap(0, 100, cyc, b1);
        check("t5_full_mask_mismatch", bus_a.mismatch_o, 1'b1);
        bus_a.mask_i = 8'hFE;
        repeat (3) @(negedge clk);
        check("t5_mismatch_hold", bus_a.mismatch_o, 1'b1);
        pulse_start(0, b1);
        check("t5_mismatch_cleared", bus_a.mismatch_o, 1'b0);
        bus_a.mask_i = 8'hFF;
        wait_done(0, 100, cyc);
        check("t5_masked_done_cycle", cyc, 35);
        check("t5_masked_mismatch", bus_a.mismatch_o, 1'b0);
        check("t5_masked_data", bus_a.data_o, 8'hF0);
`endif

        // 128 bits, DIV=4, random pattern
        pat_c = {$urandom, $urandom, $urandom, $urandom};
        run_cap(2, 1200, cyc, b1);
        check("t6_done_cycle", cyc, 1029);
        check("t6_data", bus_c.data_o, pat_c);
        check("t6_shcp_rises", rise_c, 127);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
